// File: rtl/mul8u_err_monitor_pkg.sv
// rtl/mul8u_err_monitor_pkg.sv - shared types, widths and drain length for the error monitor (ERRMON_SQ_EN)
package mul8u_errmon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Cycles spent in DRAIN: one per pipeline stage behind the accept point
`ifdef ERRMON_SQ_EN
  localparam int DRAIN_CYCLES = 3;
`else
  localparam int DRAIN_CYCLES = 2;
`endif

  // Exact product / absolute error width
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Error sum over a full window of 2^samples_log2 samples cannot overflow
  function automatic int sum_w(input int w, input int samples_log2);
    return 2 * w + samples_log2;
  endfunction

  // Counts 0..N inclusive, so one bit wider than log2(N)
  function automatic int cnt_w(input int samples_log2);
    return samples_log2 + 1;
  endfunction

  // Sum of squared errors over a full window
  function automatic int sq_sum_w(input int w, input int samples_log2);
    return 4 * w + samples_log2;
  endfunction

endpackage

// File: rtl/mul8u_err_monitor_if.sv
// rtl/mul8u_err_monitor_if.sv - sample/control/result bundle of the error monitor (ERRMON_SQ_EN)
interface mul8u_err_monitor_if #(
  parameter int W            = 8,
  parameter int SAMPLES_LOG2 = 16
);

  logic                        start;
  logic                        abort;
  logic                        in_valid;
  logic                        in_ready;
  logic [W-1:0]                A;
  logic [W-1:0]                B;
  logic [2*W-1:0]              O;
  logic                        res_valid;
  logic                        res_ready;
  logic [2*W+SAMPLES_LOG2-1:0] err_sum;
  logic [2*W-1:0]              wce;
  logic [W-1:0]                wce_a;
  logic [W-1:0]                wce_b;
  logic [SAMPLES_LOG2:0]       err_cnt;
  logic                        busy;
`ifdef ERRMON_SQ_EN
  logic [4*W+SAMPLES_LOG2-1:0] err_sq_sum;
`endif

  modport master (
    output start, abort, in_valid, A, B, O, res_ready,
    input  in_ready, res_valid, err_sum, wce, wce_a, wce_b, err_cnt, busy
`ifdef ERRMON_SQ_EN
    , input err_sq_sum
`endif
  );

  modport slave (
    input  start, abort, in_valid, A, B, O, res_ready,
    output in_ready, res_valid, err_sum, wce, wce_a, wce_b, err_cnt, busy
`ifdef ERRMON_SQ_EN
    , output err_sq_sum
`endif
  );

endinterface

// File: rtl/mul8u_err_calc.sv
// rtl/mul8u_err_calc.sv - fixed-latency pipeline turning (A, B, O) into |O - A*B| and a mismatch flag (ERRMON_SQ_EN)
module mul8u_err_calc #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           in_valid_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [2*W-1:0] o_i,
  output logic           out_valid_o,
  output logic [2*W-1:0] err_o,
  output logic           ne_o,
  output logic [W-1:0]   a_o,
  output logic [W-1:0]   b_o
`ifdef ERRMON_SQ_EN
  , output logic [4*W-1:0] sq_o
`endif
);

  localparam int P_W = 2 * W;

  logic           s1_valid_q;
  logic [W-1:0]   s1_a_q, s1_b_q;
  logic [P_W-1:0] s1_o_q, s1_p_q;
  logic [P_W-1:0] s1_p_d;

  logic           s2_valid_q;
  logic [W-1:0]   s2_a_q, s2_b_q;
  logic [P_W-1:0] s2_err_q;
  logic           s2_ne_q;
  logic [P_W-1:0] s2_err_d;
  logic           s2_ne_d;

  // Exact reference product for the incoming operands
  always_comb begin
    s1_p_d = P_W'(a_i) * P_W'(b_i);
  end

  // Absolute error, taking the subtraction in whichever direction is non-negative
  always_comb begin
    s2_ne_d  = (s1_o_q != s1_p_q);
    s2_err_d = (s1_o_q >= s1_p_q) ? (s1_o_q - s1_p_q) : (s1_p_q - s1_o_q);
  end

  // Stage 1: capture operands, approximate and exact products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_o_q     <= '0;
      s1_p_q     <= '0;
    end else begin
      s1_valid_q <= in_valid_i & ~flush_i;
      s1_a_q     <= a_i;
      s1_b_q     <= b_i;
      s1_o_q     <= o_i;
      s1_p_q     <= s1_p_d;
    end
  end

  // Stage 2: capture error magnitude and mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_err_q   <= '0;
      s2_ne_q    <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q & ~flush_i;
      s2_a_q     <= s1_a_q;
      s2_b_q     <= s1_b_q;
      s2_err_q   <= s2_err_d;
      s2_ne_q    <= s2_ne_d;
    end
  end

`ifdef ERRMON_SQ_EN
  logic           s3_valid_q;
  logic [W-1:0]   s3_a_q, s3_b_q;
  logic [P_W-1:0] s3_err_q;
  logic           s3_ne_q;
  logic [2*P_W-1:0] s3_sq_q;
  logic [2*P_W-1:0] s3_sq_d;

  // Squared error for the MSE accumulator
  always_comb begin
    s3_sq_d = (2*P_W)'(s2_err_q) * (2*P_W)'(s2_err_q);
  end

  // Stage 3: square the error, delay the remaining fields to match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_a_q     <= '0;
      s3_b_q     <= '0;
      s3_err_q   <= '0;
      s3_ne_q    <= 1'b0;
      s3_sq_q    <= '0;
    end else begin
      s3_valid_q <= s2_valid_q & ~flush_i;
      s3_a_q     <= s2_a_q;
      s3_b_q     <= s2_b_q;
      s3_err_q   <= s2_err_q;
      s3_ne_q    <= s2_ne_q;
      s3_sq_q    <= s3_sq_d;
    end
  end

  assign out_valid_o = s3_valid_q;
  assign err_o       = s3_err_q;
  assign ne_o        = s3_ne_q;
  assign a_o         = s3_a_q;
  assign b_o         = s3_b_q;
  assign sq_o        = s3_sq_q;
`else
  assign out_valid_o = s2_valid_q;
  assign err_o       = s2_err_q;
  assign ne_o        = s2_ne_q;
  assign a_o         = s2_a_q;
  assign b_o         = s2_b_q;
`endif

endmodule

// File: rtl/mul8u_err_monitor.sv
// rtl/mul8u_err_monitor.sv - windowed error statistics (sum, worst case, count) for an approximate 8x8 multiplier (ERRMON_SQ_EN)
module mul8u_err_monitor
  import mul8u_errmon_pkg::*;
#(
  parameter int W            = 8,
  parameter int SAMPLES_LOG2 = 16
) (
  input logic                clk,
  input logic                rst_n,
  mul8u_err_monitor_if.slave bus
);

  localparam int P_W = prod_w(W);
  localparam int S_W = sum_w(W, SAMPLES_LOG2);
  localparam int C_W = cnt_w(SAMPLES_LOG2);
  localparam logic [C_W-1:0] LAST_IDX  = C_W'((1 << SAMPLES_LOG2) - 1);
  localparam logic [1:0]     DRAIN_END = 2'(DRAIN_CYCLES - 1);

  state_e         state_q, state_d;
  logic [C_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [1:0]     drain_cnt_q, drain_cnt_d;
  logic           in_ready;
  logic           accept;
  logic           acc_clear;

  logic           c_valid;
  logic [P_W-1:0] c_err;
  logic           c_ne;
  logic [W-1:0]   c_a, c_b;

  logic [S_W-1:0] err_sum_q, err_sum_d;
  logic [P_W-1:0] wce_q, wce_d;
  logic [W-1:0]   wce_a_q, wce_a_d;
  logic [W-1:0]   wce_b_q, wce_b_d;
  logic [C_W-1:0] err_cnt_q, err_cnt_d;

  assign accept    = bus.in_valid & in_ready;
  assign acc_clear = (state_q == IDLE) & bus.start & ~bus.abort;

  mul8u_err_calc #(.W(W)) u_calc (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.abort),
    .in_valid_i  (accept),
    .a_i         (bus.A),
    .b_i         (bus.B),
    .o_i         (bus.O),
    .out_valid_o (c_valid),
    .err_o       (c_err),
    .ne_o        (c_ne),
    .a_o         (c_a),
    .b_o         (c_b)
`ifdef ERRMON_SQ_EN
    , .sq_o      (c_sq)
`endif
  );

`ifdef ERRMON_SQ_EN
  localparam int Q_W = sq_sum_w(W, SAMPLES_LOG2);
  logic [2*P_W-1:0] c_sq;
  logic [Q_W-1:0]   sq_sum_q, sq_sum_d;

  // Squared-error accumulator follows the same clear/update rules as err_sum
  always_comb begin
    sq_sum_d = sq_sum_q;
    if (acc_clear) begin
      sq_sum_d = '0;
    end else if (c_valid) begin
      sq_sum_d = sq_sum_q + Q_W'(c_sq);
    end
  end

  // Squared-error accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_sum_q <= '0;
    end else begin
      sq_sum_q <= sq_sum_d;
    end
  end

  assign bus.err_sq_sum = sq_sum_q;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      smp_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state; abort overrides everything, including a simultaneous start
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    drain_cnt_d = '0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d   = RUN;
            smp_cnt_d = '0;
          end
        end
        RUN: begin
          if (accept) begin
            smp_cnt_d = smp_cnt_q + 1'b1;
            if (smp_cnt_q == LAST_IDX) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == DRAIN_END) begin
            state_d     = REPORT;
            drain_cnt_d = '0;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready      = (state_q == RUN);
    bus.in_ready  = in_ready;
    bus.res_valid = (state_q == REPORT);
    bus.busy      = (state_q != IDLE);
  end

  // Accumulator next values; strict '>' keeps the earliest worst-case sample on ties
  always_comb begin
    err_sum_d = err_sum_q;
    wce_d     = wce_q;
    wce_a_d   = wce_a_q;
    wce_b_d   = wce_b_q;
    err_cnt_d = err_cnt_q;
    if (acc_clear) begin
      err_sum_d = '0;
      wce_d     = '0;
      wce_a_d   = '0;
      wce_b_d   = '0;
      err_cnt_d = '0;
    end else if (c_valid) begin
      err_sum_d = err_sum_q + S_W'(c_err);
      err_cnt_d = err_cnt_q + C_W'(c_ne);
      if (c_err > wce_q) begin
        wce_d   = c_err;
        wce_a_d = c_a;
        wce_b_d = c_b;
      end
    end
  end

  // Accumulator registers; they survive abort and are only cleared by start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_q <= '0;
      wce_q     <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      wce_q     <= wce_d;
      wce_a_q   <= wce_a_d;
      wce_b_q   <= wce_b_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_sum = err_sum_q;
  assign bus.wce     = wce_q;
  assign bus.wce_a   = wce_a_q;
  assign bus.wce_b   = wce_b_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mul8u_err_monitor.sv
// tb/tb_mul8u_err_monitor.sv - self-checking bench for mul8u_err_monitor (ERRMON_SQ_EN)
module tb_mul8u_err_monitor;

  localparam int W   = 8;
  localparam int SL2 = 4;
  localparam int N   = 16;
`ifdef ERRMON_SQ_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    longint sum;
    longint wce;
    int     a;
    int     b;
    int     cnt;
    longint sq;
  } res_t;

  typedef struct {
    int          i1;
    logic [7:0]  a1, b1;
    logic [15:0] o1;
    int          i2;
    logic [7:0]  a2, b2;
    logic [15:0] o2;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul8u_err_monitor_if #(.W(W), .SAMPLES_LOG2(SL2)) bus ();

  mul8u_err_monitor #(.W(W), .SAMPLES_LOG2(SL2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  sa [N];
  logic [7:0]  sb [N];
  logic [15:0] so [N];

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Statistics of the stored window, straight from the definitions
  function automatic res_t model();
    res_t r;
    r = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) begin
      longint p, e;
      p = longint'(sa[i]) * longint'(sb[i]);
      e = (longint'(so[i]) > p) ? longint'(so[i]) - p : p - longint'(so[i]);
      r.sum += e;
      r.sq  += e * e;
      if (e != 0) r.cnt++;
      if (e > r.wce) begin
        r.wce = e;
        r.a   = int'(sa[i]);
        r.b   = int'(sb[i]);
      end
    end
    return r;
  endfunction

  task automatic fill_exact();
    for (int i = 0; i < N; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      so[i] = 16'(sa[i]) * 16'(sb[i]);
    end
  endtask

  task automatic fill_random(input int mode_max);
    for (int i = 0; i < N; i++) begin
      int m;
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      m = $urandom_range(0, mode_max);
      if (m == 0)      so[i] = 16'(sa[i]) * 16'(sb[i]);
      else if (m == 1) so[i] = (16'(sa[i]) * 16'(sb[i])) ^ (16'd1 << $urandom_range(0, 15));
      else             so[i] = 16'($urandom);
    end
  endtask

  task automatic start_window();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("in_ready_after_start", bus.in_ready, 1);
  endtask

  // Present samples 0..upto-1 with random bubbles; stops with in_valid still high on the last one
  task automatic feed(input int upto);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < upto && guard < 400) begin
      if (guard != 0) @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.A = sa[i];
        bus.B = sb[i];
        bus.O = so[i];
      end
      #1;
      if (bus.in_valid && bus.in_ready) i++;
    end
    if (i < upto) chk("feed_timeout", 64'(i), 64'(upto));
  endtask

  task automatic compare_res(input string tag, input res_t e);
    chk({tag, "_res_valid"}, bus.res_valid, 1);
    chk({tag, "_err_sum"}, 64'(bus.err_sum), 64'(e.sum));
    chk({tag, "_wce"},     64'(bus.wce),     64'(e.wce));
    chk({tag, "_wce_a"},   64'(bus.wce_a),   64'(e.a));
    chk({tag, "_wce_b"},   64'(bus.wce_b),   64'(e.b));
    chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'(e.cnt));
`ifdef ERRMON_SQ_EN
    chk({tag, "_err_sq_sum"}, 64'(bus.err_sq_sum), 64'(e.sq));
`endif
  endtask

  // After the last accepted sample: check drain latency, results, optional hold, then acknowledge
  task automatic finish_window(input string tag, input res_t e, input int hold);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_in_ready_drop"}, bus.in_ready, 0);
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    compare_res(tag, e);
    for (int h = 0; h < hold; h++) begin
      bus.start = (h == 1);
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
      compare_res({tag, "_hold"}, e);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_res_valid_clear"}, bus.res_valid, 0);
    chk({tag, "_busy_clear"}, bus.busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_in_ready"},  bus.in_ready, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_err_sum"},   64'(bus.err_sum), 0);
    chk({tag, "_wce"},       64'(bus.wce), 0);
    chk({tag, "_wce_a"},     64'(bus.wce_a), 0);
    chk({tag, "_wce_b"},     64'(bus.wce_b), 0);
    chk({tag, "_err_cnt"},   64'(bus.err_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   seen;

    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.res_ready = 0;
    bus.A = 0; bus.B = 0; bus.O = 0;

    tbl[0] = '{-1, 0, 0, 0, -1, 0, 0, 0, '{0, 0, 0, 0, 0, 0}};
    tbl[1] = '{7, 255, 255, 0, -1, 0, 0, 0, '{65025, 65025, 255, 255, 1, 0}};
    tbl[2] = '{3, 2, 3, 10, 9, 4, 4, 12, '{8, 4, 2, 3, 2, 0}};
    tbl[3] = '{0, 10, 10, 90, 15, 1, 1, 200, '{209, 199, 1, 1, 2, 0}};
    tbl[4] = '{15, 0, 0, 16'hFFFF, -1, 0, 0, 0, '{65535, 65535, 0, 0, 1, 0}};

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 0);

    // Directed windows: random exact products plus a few planted errors
    for (int t = 0; t < 5; t++) begin
      fill_exact();
      if (tbl[t].i1 >= 0) begin
        sa[tbl[t].i1] = tbl[t].a1; sb[tbl[t].i1] = tbl[t].b1; so[tbl[t].i1] = tbl[t].o1;
      end
      if (tbl[t].i2 >= 0) begin
        sa[tbl[t].i2] = tbl[t].a2; sb[tbl[t].i2] = tbl[t].b2; so[tbl[t].i2] = tbl[t].o2;
      end
      e = tbl[t].exp;
      e.sq = model().sq;
      start_window();
      feed(N);
      finish_window($sformatf("tbl%0d", t), e, 0);
    end

    // Random windows against the reference model; the last one has every sample wrong
    for (int r = 0; r < 6; r++) begin
      if (r == 5) fill_random(1);
      else        fill_random(2);
      if (r == 5) begin
        for (int i = 0; i < N; i++) so[i] = (16'(sa[i]) * 16'(sb[i])) ^ 16'h0100;
      end
      e = model();
      start_window();
      feed(N);
      finish_window($sformatf("rnd%0d", r), e, 0);
    end

    // Hold in REPORT for 5 cycles with a stray start pulse
    fill_random(2);
    e = model();
    start_window();
    feed(N);
    finish_window("hold", e, 5);

    // Abort after 5 accepted samples
    fill_random(2);
    start_window();
    feed(5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_res_valid", bus.res_valid, 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("abort_no_report", 64'(seen), 0);

    // start together with abort in IDLE stays idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", bus.busy, 0);

    fill_exact();
    e = model();
    start_window();
    feed(N);
    finish_window("post_abort", e, 0);

    // Reset in the middle of a window that already accumulated an error
    fill_random(2);
    sa[0] = 8'd3; sb[0] = 8'd3; so[0] = 16'd100;
    start_window();
    feed(8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_reset_err_sum_nonzero", 64'(bus.err_sum != 0), 1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_in_ready", bus.in_ready, 0);
    end

    fill_random(2);
    e = model();
    start_window();
    feed(N);
    finish_window("post_reset", e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
